// File: rtl/mc_mips_core_p.sv
// Multi-cycle MIPS core: shared-memory datapath and control FSM in one block,
// with a req/ready memory handshake, illegal-instruction halt and retire pulse.

module mc_mips_core_p #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NREG     = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg
);

    localparam int unsigned RW = $clog2(NREG);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEMADR, S_MEMRD, S_WB_MEM, S_MEMWR,
        S_BRANCH, S_JUMP, S_JAL, S_JR, S_HALT
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic [31:0]       r_mdr;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [31:0]       r_alu_out;
    logic [31:0]       r_rf [NREG];

    // Instruction fields
    logic [5:0]    w_op;
    logic [5:0]    w_funct;
    logic [RW-1:0] w_rs;
    logic [RW-1:0] w_rt;
    logic [RW-1:0] w_rd;
    logic [31:0]   w_imm_sext;
    logic [31:0]   w_br_off;
    logic [31:0]   w_pc32;
    logic [31:0]   w_jtarget32;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic          w_unused_ok;

    assign w_op        = r_ir[31:26];
    assign w_funct     = r_ir[5:0];
    assign w_rs        = r_ir[21 +: RW];
    assign w_rt        = r_ir[16 +: RW];
    assign w_rd        = r_ir[11 +: RW];
    assign w_imm_sext  = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_br_off    = {w_imm_sext[29:0], 2'b00};
    assign w_pc32      = 32'(r_pc);
    assign w_jtarget32 = {w_pc32[31:28], r_ir[25:0], 2'b00};
    assign w_pc_plus4  = r_pc + PC_STEP;
    assign w_unused_ok = ^r_ir[10:6];

    // Control and datapath enables
    state_t            w_state_next;
    logic              w_req;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic              w_retire;
    logic              w_ir_we;
    logic              w_mdr_we;
    logic              w_ab_we;
    logic              w_alu_we;
    logic [31:0]       w_alu_next;
    logic              w_pc_we;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_rf_we;
    logic [RW-1:0]     w_rf_waddr;
    logic [31:0]       w_rf_wdata;

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; an incomplete assignment in always_comb would infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_addr       = r_pc;
        w_retire     = 1'b0;
        w_ir_we      = 1'b0;
        w_mdr_we     = 1'b0;
        w_ab_we      = 1'b0;
        w_alu_we     = 1'b0;
        w_alu_next   = r_alu_out;
        w_pc_we      = 1'b0;
        w_pc_next    = w_pc_plus4;
        w_rf_we      = 1'b0;
        w_rf_waddr   = w_rt;
        w_rf_wdata   = r_alu_out;

        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (mem_ready) begin
                    w_ir_we      = 1'b1;
                    w_pc_we      = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_ab_we    = 1'b1;
                w_alu_we   = 1'b1;
                w_alu_next = w_pc32 + w_br_off;
                case (w_op)
                    OP_RTYPE:     w_state_next = (w_funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_BEQ:       w_state_next = S_BRANCH;
                    OP_ADDI:      w_state_next = S_EXEC_I;
                    OP_J:         w_state_next = S_JUMP;
                    OP_JAL:       w_state_next = S_JAL;
                    default:      w_state_next = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                w_alu_we     = 1'b1;
                w_state_next = S_WB_R;
                case (w_funct)
                    FN_ADD:  w_alu_next = r_a + r_b;
                    FN_SUB:  w_alu_next = r_a - r_b;
                    FN_AND:  w_alu_next = r_a & r_b;
                    FN_OR:   w_alu_next = r_a | r_b;
                    FN_SLT:  w_alu_next = ($signed(r_a) < $signed(r_b)) ? 32'd1 : 32'd0;
                    default: begin
                        w_alu_we     = 1'b0;
                        w_state_next = S_HALT;
                    end
                endcase
            end
            S_WB_R: begin
                w_rf_we      = 1'b1;
                w_rf_waddr   = w_rd;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_EXEC_I: begin
                w_alu_we     = 1'b1;
                w_alu_next   = r_a + w_imm_sext;
                w_state_next = S_WB_I;
            end
            S_WB_I: begin
                w_rf_we      = 1'b1;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEMADR: begin
                w_alu_we     = 1'b1;
                w_alu_next   = r_a + w_imm_sext;
                w_state_next = (w_op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_req  = 1'b1;
                w_addr = r_alu_out[ADDR_W-1:0];
                if (mem_ready) begin
                    w_mdr_we     = 1'b1;
                    w_state_next = S_WB_MEM;
                end
            end
            S_WB_MEM: begin
                w_rf_we      = 1'b1;
                w_rf_wdata   = r_mdr;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEMWR: begin
                w_req  = 1'b1;
                w_we   = 1'b1;
                w_addr = r_alu_out[ADDR_W-1:0];
                if (mem_ready) begin
                    w_retire     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                if (r_a == r_b) begin
                    w_pc_we   = 1'b1;
                    w_pc_next = r_alu_out[ADDR_W-1:0];
                end
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JUMP: begin
                w_pc_we      = 1'b1;
                w_pc_next    = w_jtarget32[ADDR_W-1:0];
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JAL: begin
                w_pc_we      = 1'b1;
                w_pc_next    = w_jtarget32[ADDR_W-1:0];
                w_rf_we      = 1'b1;
                w_rf_waddr   = {RW{1'b1}};
                w_rf_wdata   = w_pc32;
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JR: begin
                w_pc_we      = 1'b1;
                w_pc_next    = r_a[ADDR_W-1:0];
                w_retire     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_HALT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before the edge, independent of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC[ADDR_W-1:0];
            r_ir      <= '0;
            r_mdr     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pc_we)  r_pc      <= w_pc_next;
            if (w_ir_we)  r_ir      <= mem_rdata;
            if (w_mdr_we) r_mdr     <= mem_rdata;
            if (w_alu_we) r_alu_out <= w_alu_next;
            if (w_ab_we) begin
                r_a <= r_rf[w_rs];
                r_b <= r_rf[w_rt];
            end
        end
    end

    // NOTE: the register file must come up all-zero, so it is built from
    // resettable flops rather than a RAM macro; entry 0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (w_rf_we && (w_rf_waddr != '0)) begin
            r_rf[w_rf_waddr] <= w_rf_wdata;
        end
    end

    // Request and retire are forced low during reset even though FETCH is the reset state
    assign mem_req   = w_req & ~rst;
    assign mem_we    = w_we;
    assign mem_addr  = w_addr;
    assign mem_wdata = r_b;
    assign retire    = w_retire & ~rst;
    assign halted    = (r_state == S_HALT);
    assign pc_dbg    = r_pc;

endmodule

// File: tb/tb_mc_mips_core_p.sv
// Directed bench for mc_mips_core_p: runs a small program against a unified
// memory model and compares fetch order, latencies and stored results.

module tb_mc_mips_core_p;

    localparam int unsigned ADDR_W   = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_0040;
    localparam int unsigned NREG     = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              retire;
    logic              halted;
    logic [ADDR_W-1:0] pc_dbg;

    always #5 clk = ~clk;

    mc_mips_core_p #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .NREG     (NREG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .retire    (retire),
        .halted    (halted),
        .pc_dbg    (pc_dbg)
    );

    // Unified memory model; the store to 0x408 is held off for three cycles
    logic [31:0] mem [0:1023];
    logic        bw_en    = 1'b0;
    logic [15:0] bw_addr  = '0;
    logic [31:0] bw_data  = '0;
    logic        force_nr = 1'b0;
    int          wr_wait  = 0;

    assign mem_rdata = mem[mem_addr[11:2]];
    assign mem_ready = !force_nr && !(mem_req && mem_we && mem_addr == 16'h0408 && wr_wait < 3);

    always @(posedge clk) begin
        if (bw_en) mem[bw_addr[11:2]] <= bw_data;
        else if (mem_req && mem_we && mem_ready) mem[mem_addr[11:2]] <= mem_wdata;
        if (mem_req && mem_we && !mem_ready) wr_wait <= wr_wait + 1;
    end

    // Trace monitor: fetch start address, per-instruction latency, PC at retire
    int          cyc       = 0;
    int          start_cyc = 0;
    int          n_ret     = 0;
    int          sw_hold   = 0;
    int          sw_bad    = 0;
    logic        new_instr = 1'b1;
    logic [15:0] fetch_q [$];
    int          lat_q   [$];
    logic [15:0] rpc_q   [$];

    always @(negedge clk) begin
        if (rst) begin
            new_instr <= 1'b1;
        end else begin
            cyc <= cyc + 1;
            if (new_instr && mem_req) begin
                fetch_q.push_back(mem_addr);
                start_cyc <= cyc;
                new_instr <= 1'b0;
            end
            if (retire) begin
                lat_q.push_back(cyc - start_cyc + 1);
                rpc_q.push_back(pc_dbg);
                n_ret     <= n_ret + 1;
                new_instr <= 1'b1;
            end
            if (mem_req && mem_we && mem_addr == 16'h0408) begin
                sw_hold <= sw_hold + 1;
                if (mem_wdata !== 32'h0000_02AA) sw_bad <= sw_bad + 1;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fq(input int idx);
        return (idx < fetch_q.size()) ? 32'(fetch_q[idx]) : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] lq(input int idx);
        return (idx < lat_q.size()) ? 32'(lat_q[idx]) : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [27:0] target);
        return {op, target[27:2]};
    endfunction

    task automatic poke(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        bw_en   = 1'b1;
        bw_addr = a;
        bw_data = d;
        @(negedge clk);
        bw_en   = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] addr;
        int          lat;
    } trace_t;

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic [31:0] exp;
    } memchk_t;

    trace_t  tr [24];
    memchk_t mc [8];

    initial begin
        int base_f;
        int base_l;
        int ret_before;
        int req_seen;
        int not_halted;

        // Expected fetch order and cycles per instruction for the main program
        for (int i = 0; i < 10; i++) tr[i] = '{addr: 16'(32'h40 + 4 * i), lat: 4};
        tr[10] = '{addr: 16'h0068, lat: 7};
        tr[11] = '{addr: 16'h006C, lat: 5};
        tr[12] = '{addr: 16'h0070, lat: 3};
        tr[13] = '{addr: 16'h0074, lat: 3};
        tr[14] = '{addr: 16'h0200, lat: 3};
        tr[15] = '{addr: 16'h0300, lat: 3};
        for (int i = 0; i < 7; i++) tr[16 + i] = '{addr: 16'(32'h204 + 4 * i), lat: 4};
        tr[23] = '{addr: 16'h0220, lat: 0};

        mc[0] = '{name: "sw_stalled", addr: 16'h0408, exp: 32'h0000_02AA};
        mc[1] = '{name: "sub_r3",     addr: 16'h0400, exp: 32'd4};
        mc[2] = '{name: "slt_r4",     addr: 16'h0404, exp: 32'd1};
        mc[3] = '{name: "slt_neg_r5", addr: 16'h040C, exp: 32'd1};
        mc[4] = '{name: "r0_zero",    addr: 16'h0410, exp: 32'd0};
        mc[5] = '{name: "lw_r7",      addr: 16'h0414, exp: 32'h0000_02AA};
        mc[6] = '{name: "jal_r31",    addr: 16'h0418, exp: 32'h0000_0204};
        mc[7] = '{name: "addi_neg",   addr: 16'h041C, exp: 32'hFFFF_FFFF};

        // Main program, loaded while reset is held
        poke(16'h0040, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        poke(16'h0044, enc_i(6'h08, 5'd0, 5'd1, 16'd7));
        poke(16'h0048, enc_i(6'h08, 5'd0, 5'd2, 16'd3));
        poke(16'h004C, enc_r(5'd1, 5'd2, 5'd3, 6'h22));
        poke(16'h0050, enc_r(5'd2, 5'd1, 5'd4, 6'h2A));
        poke(16'h0054, enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF));
        poke(16'h0058, enc_r(5'd1, 5'd2, 5'd5, 6'h2A));
        poke(16'h005C, enc_i(6'h08, 5'd0, 5'd0, 16'd9));
        poke(16'h0060, enc_i(6'h08, 5'd0, 5'd6, 16'h02AA));
        poke(16'h0064, enc_i(6'h08, 5'd0, 5'd2, 16'h0400));
        poke(16'h0068, enc_i(6'h2B, 5'd2, 5'd6, 16'd8));
        poke(16'h006C, enc_i(6'h23, 5'd2, 5'd7, 16'd8));
        poke(16'h0070, enc_i(6'h04, 5'd1, 5'd2, 16'd4));
        poke(16'h0074, enc_j(6'h02, 28'h0000200));
        poke(16'h0200, enc_j(6'h03, 28'h0000300));
        poke(16'h0300, enc_r(5'd31, 5'd0, 5'd0, 6'h08));
        poke(16'h0204, enc_i(6'h2B, 5'd2, 5'd3, 16'd0));
        poke(16'h0208, enc_i(6'h2B, 5'd2, 5'd4, 16'd4));
        poke(16'h020C, enc_i(6'h2B, 5'd2, 5'd5, 16'd12));
        poke(16'h0210, enc_i(6'h2B, 5'd2, 5'd0, 16'd16));
        poke(16'h0214, enc_i(6'h2B, 5'd2, 5'd7, 16'd20));
        poke(16'h0218, enc_i(6'h2B, 5'd2, 5'd31, 16'd24));
        poke(16'h021C, enc_i(6'h2B, 5'd2, 5'd1, 16'd28));
        poke(16'h0220, {6'h3F, 26'd0});

        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_retire",  32'(retire),  32'd0);
        check("rst_halted",  32'(halted),  32'd0);
        check("rst_pc",      32'(pc_dbg),  32'h40);

        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
        #1;
        check("halted_set", 32'(halted), 32'd1);

        check("fetch_count",  32'(fetch_q.size()), 32'd24);
        check("retire_count", 32'(lat_q.size()),   32'd23);
        check("first_pc_dbg", (rpc_q.size() > 0) ? 32'(rpc_q[0]) : 32'hxxxx_xxxx, 32'h44);
        for (int i = 0; i < 24; i++) begin
            check($sformatf("fetch_addr[%0d]", i), fq(i), 32'(tr[i].addr));
            if (i < 23) check($sformatf("latency[%0d]", i), lq(i), 32'(tr[i].lat));
        end
        for (int i = 0; i < 8; i++) check(mc[i].name, mem[mc[i].addr[11:2]], mc[i].exp);
        check("sw_hold_cycles", 32'(sw_hold), 32'd4);
        check("sw_data_stable", 32'(sw_bad),  32'd0);

        // Halt is absorbing: no requests and no PC movement
        req_seen   = 0;
        not_halted = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0) req_seen++;
            if (halted !== 1'b1) not_halted++;
        end
        #1;
        check("halt_no_req", 32'(req_seen),   32'd0);
        check("halt_sticky", 32'(not_halted), 32'd0);
        check("halt_pc",     32'(pc_dbg),     32'h224);

        // Reset out of HALT, then stall the first fetch and reset mid-wait
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_clears_halt", 32'(halted), 32'd0);
        check("rst_pc_reload",   32'(pc_dbg), 32'h40);
        force_nr = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ret_before = n_ret;
        tick(4);
        check("wait_req",       32'(mem_req),  32'd1);
        check("wait_we",        32'(mem_we),   32'd0);
        check("wait_addr",      32'(mem_addr), 32'h40);
        check("wait_no_retire", 32'(n_ret - ret_before), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_drops_req", 32'(mem_req), 32'd0);
        check("rst_wait_pc",   32'(pc_dbg),  32'h40);
        check("rst_wait_halt", 32'(halted),  32'd0);

        // Taken branch to itself: j 0x100 then beq $1,$1,-1 at 0x100
        poke(16'h0040, enc_j(6'h02, 28'h0000100));
        poke(16'h0100, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF));
        force_nr = 1'b0;
        base_f = fetch_q.size();
        base_l = lat_q.size();
        @(posedge clk);
        #1 rst = 1'b0;
        tick(12);
        check("loop_fetch0", fq(base_f),     32'h40);
        check("loop_fetch1", fq(base_f + 1), 32'h100);
        check("loop_fetch2", fq(base_f + 2), 32'h100);
        check("loop_fetch3", fq(base_f + 3), 32'h100);
        check("loop_lat_j",  lq(base_l),     32'd3);
        check("loop_lat_b0", lq(base_l + 1), 32'd3);
        check("loop_lat_b1", lq(base_l + 2), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_mips_core_p.md
Name: mc_mips_core_p

Overview:
- Parametrised multi-cycle MIPS core.
- Merges the shared-memory multi-cycle datapath (PC, IR, MDR, A/B, ALUOut, register file) with its control FSM in one block.
- Adds a ready/valid-style memory handshake with wait states, a configurable reset vector and address width, illegal-opcode halt, and a retire pulse.
- Sits between the unified instruction/data memory model and the testbench.

Parameters:
ADDR_W, 32, memory address width (8..32); PC and mem_addr are ADDR_W bits, PC+4 wraps modulo 2^ADDR_W
RESET_PC, 0, PC value loaded on reset (word aligned)
NREG, 32, register count (power of 2, 8..32); register index = low log2(NREG) bits of instruction field

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
mem_req  out  1  memory access request
mem_we  out  1  1 = write (sw), 0 = read; valid while mem_req
mem_addr  out  ADDR_W  byte address
mem_wdata  out  32  store data (B register)
mem_rdata  in  32  read data, sampled in the cycle mem_ready=1
mem_ready  in  1  access completes at the rising edge where mem_req && mem_ready
retire  out  1  one-cycle pulse in the last cycle of each instruction
halted  out  1  sticky, set on illegal instruction
pc_dbg  out  ADDR_W  current PC

Behaviour:
- Reset (async, active-high): PC=RESET_PC, IR/MDR/A/B/ALUOut=0, all registers=0, state=FETCH. mem_req, retire and halted are 0 while rst is high.
- Register 0 always reads 0; writes to it are ignored. RF writes occur at a clock edge and are visible to DECODE of the next instruction.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. Holds while mem_ready=0. On ready: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE: A<=R[rs], B<=R[rt], ALUOut<=PC+(sext(imm16)<<2). Dispatch on opcode:
  - 000000 -> funct 001000 (jr) ? JR : EXEC_R
  - 100011/101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> EXEC_I
  - 000010 -> JUMP
  - 000011 -> JAL
  - other -> HALT
- EXEC_R: ALUOut<=A op B per funct. Supported: add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed). Unsupported funct -> HALT. Otherwise -> WB_R.
- WB_R: R[rd]<=ALUOut; retire; -> FETCH.
- EXEC_I: ALUOut<=A+sext(imm) -> WB_I. WB_I: R[rt]<=ALUOut; retire; -> FETCH.
- MEMADR: ALUOut<=A+sext(imm); lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, mem_we=0, mem_addr=ALUOut[ADDR_W-1:0]. Holds until mem_ready; then MDR<=mem_rdata -> WB_MEM.
- WB_MEM: R[rt]<=MDR; retire; -> FETCH.
- MEMWR: mem_req=1, mem_we=1, mem_wdata=B. Holds until mem_ready; retire in the ready cycle; -> FETCH.
- BRANCH: if A==B, PC<=ALUOut. Retire; -> FETCH.
- JUMP: PC<={PC[ADDR_W-1:28], imm26, 2'b00}, truncated/aligned to ADDR_W. Retire; -> FETCH.
- JAL: same PC update as JUMP, plus R[NREG-1]<=PC (already PC+4). Retire; -> FETCH.
- JR: PC<=A. Retire; -> FETCH.
- HALT: absorbing state. halted=1, mem_req=0, no PC/RF change. Only rst exits.
- Arithmetic is 32-bit wraparound; no overflow trap.
- Latency with zero wait states:
  - 3 cycles: beq, j, jal, jr
  - 4 cycles: R-type, addi, sw
  - 5 cycles: lw
  - each cycle with mem_ready=0 in FETCH/MEMRD/MEMWR adds 1.
- Outside FETCH/MEMRD/MEMWR: mem_req=0; mem_addr/mem_wdata are don't-care.
- Address outputs, mem_we and mem_wdata are stable while mem_req is held.
- Reset mid-wait: mem_req drops immediately (async). No RF/PC write from the aborted instruction.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Reset, RESET_PC=0x40, mem_ready=1, addi $1,$0,5 -> first mem_addr=0x40; WB_I writes R1=5 at cycle 4; retire pulses once; pc_dbg=0x44.
- R1=7, R2=3; sub $3,$1,$2 then slt $4,$2,$1 -> R3=4, R4=1. R1=-1 with slt $5,$1,$2 -> R5=1. addi $0,$0,9 -> R0 remains 0.
- sw $1,8($2) with mem_ready low for 3 cycles in MEMWR -> mem_req/mem_we/mem_addr=R2+8/mem_wdata stable for 4 cycles; instruction takes 7 cycles. lw back -> same value in rt, 5 cycles.
- beq $1,$1,-1 at PC 0x100 -> next fetch at 0x100. beq $1,$2,+4 with unequal regs -> next fetch 0x104.
- jal at 0x200 target 0x300, then jr $31 -> R31=0x204; fetch order 0x300, then 0x204; each takes 3 cycles.
- Opcode 0x3F -> halted=1 after DECODE, mem_req stays 0 for 20 cycles. Assert rst mid-FETCH wait -> halted=0 and PC=RESET_PC immediately.
